// File: rtl/start_store_pkg.sv
// -----------------------------------------------------------------------------
// start_store_pkg
// Shared definitions for the dual-bank backprop store:
//   - default geometry (layer count, element width, elements per vector)
//   - bank-select codes presented on load_data_set
//   - helper that gives the packed vector width for a given geometry
// -----------------------------------------------------------------------------
package start_store_pkg;

  localparam int MAX_LAYER_SIZE_DEF = 5;
  localparam int DATA_SIZE_DEF      = 16;
  localparam int SIZE_DEF           = 3;

  // Bank-select codes on load_data_set.
  localparam logic [31:0] SET_START = 32'd0;
  localparam logic [31:0] SET_ACT   = 32'd1;

  // Width of one packed vector: `size` Q8.8 words side by side.
  function automatic int vec_width(input int data_size, input int size);
    return data_size * size;
  endfunction

  localparam int VEC_W_DEF = DATA_SIZE_DEF * SIZE_DEF;

endpackage

// File: rtl/start_store_bank.sv
// -----------------------------------------------------------------------------
// start_store_bank
// One bank of packed-vector registers: synchronous clear, single write port,
// combinational read port. The parent guarantees that indices are in range.
//   clk      in   rising-edge clock
//   i_clr    in   synchronous clear of every entry (wins over write)
//   i_we     in   write enable
//   i_widx   in   write index
//   i_wdata  in   write data
//   i_ridx   in   read index
//   o_rdata  out  current contents of entry i_ridx
// -----------------------------------------------------------------------------
module start_store_bank
  import start_store_pkg::*;
#(
  parameter int DEPTH = MAX_LAYER_SIZE_DEF * SIZE_DEF,
  parameter int WIDTH = VEC_W_DEF,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  // Combinational read returns pre-edge contents, which gives the parent
  // read-before-write behaviour on a same-cycle store/load to one entry.
  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/start_store.sv
// -----------------------------------------------------------------------------
// start_store
// Dual-bank store for the backprop stack. Each store writes a "start"
// (pre-activation) vector and an "act" (activation) vector into the same
// slot, addressed by layer and row (entry = address*size + row). A
// registered read port returns either bank one cycle after load.
//   clk               in   rising-edge clock
//   reset_counter     in   synchronous active-high clear of both banks and load_data
//   store             in   write enable (both banks together)
//   store_address     in   write layer index
//   store_row         in   write row index
//   store_start_data  in   start vector, element 0 in the MSBs
//   store_act_data    in   act vector, same packing
//   load              in   read enable
//   load_address      in   read layer index
//   load_row          in   read row index
//   load_data_set     in   0 = start bank, 1 = act bank
//   load_data         out  registered read data (0 for any invalid request)
// -----------------------------------------------------------------------------
module start_store
  import start_store_pkg::*;
#(
  parameter int max_layer_size = MAX_LAYER_SIZE_DEF,
  parameter int data_size      = DATA_SIZE_DEF,
  parameter int size           = SIZE_DEF
) (
  input  logic                      clk,
  input  logic                      reset_counter,
  input  logic                      store,
  input  logic [31:0]               store_address,
  input  logic [31:0]               store_row,
  input  logic [data_size*size-1:0] store_start_data,
  input  logic [data_size*size-1:0] store_act_data,
  input  logic                      load,
  input  logic [31:0]               load_address,
  input  logic [31:0]               load_row,
  input  logic [31:0]               load_data_set,
  output logic [data_size*size-1:0] load_data
);

  localparam int VW    = vec_width(data_size, size);
  localparam int DEPTH = max_layer_size * size;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             w_st_ok;
  logic             w_ld_ok;
  logic [IDX_W-1:0] w_widx;
  logic [IDX_W-1:0] w_ridx;
  logic [VW-1:0]    w_start_rd;
  logic [VW-1:0]    w_act_rd;
  logic [VW-1:0]    w_sel_rd;
  logic [VW-1:0]    r_load_data;

  // Range checks are full 32-bit unsigned compares, so large addresses can
  // never alias into the array through truncation.
  assign w_st_ok = store
                 && (store_address < 32'(max_layer_size))
                 && (store_row     < 32'(size));

  assign w_ld_ok = (load_address < 32'(max_layer_size))
                 && (load_row    < 32'(size))
                 && ((load_data_set == SET_START) || (load_data_set == SET_ACT));

  // Once in range, address*size+row fits in IDX_W bits, so the narrow
  // arithmetic is exact.
  assign w_widx = IDX_W'(store_address) * IDX_W'(size) + IDX_W'(store_row);
  assign w_ridx = IDX_W'(load_address)  * IDX_W'(size) + IDX_W'(load_row);

  start_store_bank #(
    .DEPTH (DEPTH),
    .WIDTH (VW),
    .IDX_W (IDX_W)
  ) u_start_bank (
    .clk     (clk),
    .i_clr   (reset_counter),
    .i_we    (w_st_ok),
    .i_widx  (w_widx),
    .i_wdata (store_start_data),
    .i_ridx  (w_ridx),
    .o_rdata (w_start_rd)
  );

  start_store_bank #(
    .DEPTH (DEPTH),
    .WIDTH (VW),
    .IDX_W (IDX_W)
  ) u_act_bank (
    .clk     (clk),
    .i_clr   (reset_counter),
    .i_we    (w_st_ok),
    .i_widx  (w_widx),
    .i_wdata (store_act_data),
    .i_ridx  (w_ridx),
    .o_rdata (w_act_rd)
  );

  always_comb begin
    w_sel_rd = '0;
    if (w_ld_ok) begin
      w_sel_rd = (load_data_set == SET_ACT) ? w_act_rd : w_start_rd;
    end
  end

  // Read register: holds its value while load is low.
  always_ff @(posedge clk) begin
    if (reset_counter) begin
      r_load_data <= '0;
    end else if (load) begin
      r_load_data <= w_sel_rd;
    end
  end

  assign load_data = r_load_data;

endmodule

// File: tb/tb_start_store.sv
// -----------------------------------------------------------------------------
// tb_start_store
// Directed bench for start_store: reset, basic write/read of both banks,
// slot isolation, out-of-range store/load, bad bank select, same-cycle
// read-before-write, hold on load=0, negative values and mid-run reset.
// -----------------------------------------------------------------------------
module tb_start_store;

  localparam int VW = 48;

  logic          clk = 1'b0;
  logic          reset_counter;
  logic          store;
  logic [31:0]   store_address;
  logic [31:0]   store_row;
  logic [VW-1:0] store_start_data;
  logic [VW-1:0] store_act_data;
  logic          load;
  logic [31:0]   load_address;
  logic [31:0]   load_row;
  logic [31:0]   load_data_set;
  logic [VW-1:0] load_data;

  int n_vec = 0;
  int n_err = 0;

  start_store #(
    .max_layer_size (5),
    .data_size      (16),
    .size           (3)
  ) dut (
    .clk              (clk),
    .reset_counter    (reset_counter),
    .store            (store),
    .store_address    (store_address),
    .store_row        (store_row),
    .store_start_data (store_start_data),
    .store_act_data   (store_act_data),
    .load             (load),
    .load_address     (load_address),
    .load_row         (load_row),
    .load_data_set    (load_data_set),
    .load_data        (load_data)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [VW-1:0] exp);
    n_vec++;
    assert (load_data === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, load_data, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] r,
                          input logic [VW-1:0] s, input logic [VW-1:0] ac);
    store = 1'b1; store_address = a; store_row = r;
    store_start_data = s; store_act_data = ac;
    tick();
    store = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] r,
                         input logic [31:0] set);
    load = 1'b1; load_address = a; load_row = r; load_data_set = set;
    tick();
    load = 1'b0;
  endtask

  initial begin
    reset_counter = 1'b1; store = 1'b0; load = 1'b0;
    store_address = '0; store_row = '0; store_start_data = '0; store_act_data = '0;
    load_address = '0; load_row = '0; load_data_set = '0;
    #2;
    tick();
    reset_counter = 1'b0;
    check("reset_load_data", 48'h0);

    do_load(0, 0, 0); check("reset_a0r0_start", 48'h0);
    do_load(0, 0, 1); check("reset_a0r0_act",   48'h0);

    // Basic write then read of both banks.
    do_store(2, 1, 48'h0100_0200_0300, 48'h0400_0500_0600);
    do_load(2, 1, 0); check("basic_start", 48'h0100_0200_0300);
    do_load(2, 1, 1); check("basic_act",   48'h0400_0500_0600);

    // Isolation between slots, including the last valid slot.
    do_store(0, 0, 48'h1111_2222_3333, 48'h4444_5555_6666);
    do_store(4, 2, 48'h7777_8888_9999, 48'hAAAA_BBBB_CCCC);
    do_load(0, 0, 0); check("iso_a0r0_start", 48'h1111_2222_3333);
    do_load(0, 0, 1); check("iso_a0r0_act",   48'h4444_5555_6666);
    do_load(4, 2, 0); check("iso_a4r2_start", 48'h7777_8888_9999);
    do_load(4, 2, 1); check("iso_a4r2_act",   48'hAAAA_BBBB_CCCC);
    do_load(1, 0, 0); check("iso_a1r0_unwritten", 48'h0);
    do_load(2, 1, 0); check("iso_a2r1_kept", 48'h0100_0200_0300);

    // Out-of-range stores are ignored (row 3 of addr 0 would alias addr 1 row 0).
    do_store(5, 0, 48'hDEAD_BEEF_0001, 48'hDEAD_BEEF_0002);
    do_store(0, 3, 48'hDEAD_BEEF_0003, 48'hDEAD_BEEF_0004);
    do_store(32'h8000_0000, 0, 48'hDEAD_BEEF_0005, 48'hDEAD_BEEF_0006);
    do_load(1, 0, 0); check("oor_store_no_alias", 48'h0);
    do_load(0, 0, 0); check("oor_store_a0r0",     48'h1111_2222_3333);
    do_load(4, 2, 1); check("oor_store_a4r2",     48'hAAAA_BBBB_CCCC);

    // Out-of-range loads and bad bank select clear load_data.
    do_load(5, 0, 0); check("oor_load_addr", 48'h0);
    do_load(4, 2, 0); check("reload_nonzero", 48'h7777_8888_9999);
    do_load(1, 3, 0); check("oor_load_row", 48'h0);
    do_load(2, 1, 1); check("reload_nonzero2", 48'h0400_0500_0600);
    do_load(2, 1, 2); check("bad_set", 48'h0);

    // Same-cycle store and load: old value is returned, new one next read.
    do_store(1, 2, 48'h0A0A_0B0B_0C0C, 48'h0D0D_0E0E_0F0F);
    store = 1'b1; store_address = 1; store_row = 2;
    store_start_data = 48'h1234_5678_9ABC; store_act_data = 48'h0FED_CBA9_8765;
    load = 1'b1; load_address = 1; load_row = 2; load_data_set = 0;
    tick();
    store = 1'b0; load = 1'b0;
    check("rbw_old", 48'h0A0A_0B0B_0C0C);
    do_load(1, 2, 0); check("rbw_new_start", 48'h1234_5678_9ABC);
    tick(); tick();
    check("hold_load0", 48'h1234_5678_9ABC);
    do_load(1, 2, 1); check("rbw_new_act", 48'h0FED_CBA9_8765);

    // Negative Q8.8 values pass through bit-exact.
    do_store(3, 0, 48'hFF00_FF00_FF00, 48'hFF00_0100_8000);
    do_load(3, 0, 0); check("neg_start", 48'hFF00_FF00_FF00);
    do_load(3, 0, 1); check("neg_act",   48'hFF00_0100_8000);

    // Reset with a store and load pending: reset wins, everything reads 0.
    reset_counter = 1'b1;
    store = 1'b1; store_address = 3; store_row = 1;
    store_start_data = 48'h5555_5555_5555; store_act_data = 48'h6666_6666_6666;
    load = 1'b1; load_address = 3; load_row = 0; load_data_set = 0;
    tick();
    reset_counter = 1'b0; store = 1'b0; load = 1'b0;
    check("midreset_load_data", 48'h0);
    do_load(2, 1, 0); check("midreset_a2r1",   48'h0);
    do_load(3, 0, 1); check("midreset_a3r0",   48'h0);
    do_load(3, 1, 0); check("midreset_a3r1",   48'h0);
    do_load(4, 2, 1); check("midreset_a4r2",   48'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/start_store.md
Name: start_store

Overview:
- Dual-bank register store for the backprop stack.
- Each store writes two vectors to the same slot: a "start" vector (pre-activation values) and an "act" vector (activation values).
- Slots are addressed by layer (address) and row.
- The backprop engine later reads back either bank through a registered read port.
- Data are packed vectors of `size` signed Q8.8 fixed-point words.

Parameters:
- max_layer_size, 5, number of layer addresses (valid 0..max_layer_size-1)
- data_size, 16, bits per element (Q8.8 signed)
- size, 3, elements per vector; also the number of rows per layer (valid rows 0..size-1)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_counter  in  1  synchronous, active-high reset
- store  in  1  write enable
- store_address  in  32  layer index for write
- store_row  in  32  row index for write
- store_start_data  in  data_size*size  start vector; element i at bits [data_size*(size-i)-1 -: data_size], element 0 in MSBs
- store_act_data  in  data_size*size  act vector; same packing as store_start_data
- load  in  1  read enable
- load_address  in  32  layer index for read
- load_row  in  32  row index for read
- load_data_set  in  32  bank select: 0 = start bank, 1 = act bank
- load_data  out  data_size*size  registered read data; same packing as the write vectors

Behaviour:
- Storage:
  - Two banks (start, act), each max_layer_size*size entries of data_size*size bits.
  - Entry index = address*size + row.
- Reset:
  - When reset_counter=1 at a rising edge, every entry in both banks clears to 0 and load_data clears to 0.
  - Reset has priority over store and load in the same cycle.
  - Reset in the middle of a store/load sequence discards all prior contents.
- Write:
  - When store=1 and reset_counter=0 at an edge, with store_address<max_layer_size and store_row<size:
    - start bank[idx] <= store_start_data
    - act bank[idx] <= store_act_data
  - Both banks are written together.
  - Out-of-range address or row: write ignored, no state change.
- Read:
  - When load=1 and reset_counter=0 at an edge, load_data <= the selected bank entry. Latency is 1 cycle (data valid after the edge that samples load).
  - Out-of-range address or row, or load_data_set not 0/1: load_data <= 0.
  - When load=0: load_data holds its previous value.
- Simultaneous store and load to the same entry: read-before-write; load_data gets the old contents, and the new value is visible from the next read.
- No arithmetic is performed; data pass through bit-exact. Index compares are unsigned 32-bit.
- No handshake or busy signal; one store and one load can be accepted every cycle.

Decomposition:
- Shared package holds:
  - data_size/size defaults
  - bank-select constants SET_START=0, SET_ACT=1
  - the vector-width expression data_size*size
- One natural sub-module: start_store_bank.
  - Parameterised register array with synchronous clear, write-enable/index, and combinational read by index.
  - Instantiated twice (start, act).
- The top level does range checking, index computation, the bank mux and the load_data register.

Test Plan:
- Reset: assert reset_counter for 1 cycle -> load_data=0; then load addr 0 row 0 set 0 and set 1 -> 0 in both.
- Basic write/read:
  - store=1, addr 2, row 1, start={1,2,3}<<8 (0x0100_0200_0300), act={4,5,6}<<8.
  - Next cycle load addr 2 row 1 set 0 -> 0x010002000300 one cycle later.
  - Set 1 -> 0x040005000600.
- Isolation: write addr 0 row 0 and addr 4 row 2 with distinct values -> each reads back its own data; unwritten addr 1 row 0 reads 0.
- Boundaries:
  - store addr 5 (== max_layer_size) or row 3 -> ignored; existing data unchanged.
  - load addr 5 -> load_data=0.
  - load_data_set=2 -> 0.
- Same-cycle store+load to addr 1 row 2 holding old value X, writing Y -> load_data=X; the following load returns Y. load=0 afterwards -> load_data stays Y.
- Reset mid-sequence after several stores -> all reads return 0. Negative values (-1<<8 = 0xFF00) round-trip unchanged.
